disk_loader: RTL and testbench

Sequential copy engine that moves a program image from the hard-disk model to instruction memory. It replaces the software `ldk`/`sim` copy loop. It sits between the disk's read port (address out, registered data in) and the instruction memory write port. The OS starts it with a base disk address, a base instruction address and a word limit, then polls `busy` or waits for `done`.

---
 rtl/disk_loader.sv | 113 +++++++++++
 tb/tb_disk_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_loader.sv
// Disk-to-instruction-memory copy engine.
// Optional halt-opcode early stop: define DISK_LOADER_HALT_STOP_EN.
module disk_loader #(
    parameter logic [5:0] HALT_OPCODE = 6'b011000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      disk_base,
    input  logic [31:0]      imem_base,
    input  logic [CNT_W-1:0] max_words,
    output logic [31:0]      disk_addr,
    input  logic [31:0]      disk_data,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             halt_seen
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t           state;
    logic [31:0]      dbase_r;
    logic [31:0]      ibase_r;
    logic [CNT_W-1:0] max_r;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_inc;
    logic             halt_hit;
    logic             stop;

    assign idx_inc   = idx + CNT_W'(1);
    assign disk_addr = dbase_r + 32'(idx);
    assign imem_addr = ibase_r + 32'(idx);
    assign halt_hit  = (imem_data[31:26] == HALT_OPCODE);

`ifdef DISK_LOADER_HALT_STOP_EN
    assign stop = (idx_inc == max_r) || halt_hit;
`else
    assign stop = (idx_inc == max_r);
    // Opcode inspection is compiled out; the flag stays low.
    assign halt_seen = halt_hit & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dbase_r   <= '0;
            ibase_r   <= '0;
            max_r     <= '0;
            idx       <= '0;
            count     <= '0;
            imem_data <= '0;
            imem_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DISK_LOADER_HALT_STOP_EN
            halt_seen <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dbase_r <= disk_base;
                        ibase_r <= imem_base;
                        max_r   <= max_words;
                        idx     <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
`ifdef DISK_LOADER_HALT_STOP_EN
                        halt_seen <= 1'b0;
`endif
                        if (max_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    imem_data <= disk_data;
                    imem_we   <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    idx   <= idx_inc;
                    count <= count + CNT_W'(1);
                    if (stop) begin
                        state <= DONE;
                        done  <= 1'b1;
`ifdef DISK_LOADER_HALT_STOP_EN
                        halt_seen <= halt_hit;
`endif
                    end else begin
                        state <= READ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disk_loader.sv
// Randomized self-checking bench for disk_loader against a
// transaction-level model (word count, halt scan, cycle index).
module tb_disk_loader;

    localparam int         CNT_W = 16;
    localparam logic [5:0] HALT  = 6'b011000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      disk_base = '0;
    logic [31:0]      imem_base = '0;
    logic [CNT_W-1:0] max_words = '0;
    logic [31:0]      disk_addr;
    logic [31:0]      disk_data = '0;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             halt_seen;

    disk_loader #(.HALT_OPCODE(HALT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .disk_base(disk_base), .imem_base(imem_base),
        .max_words(max_words), .disk_addr(disk_addr),
        .disk_data(disk_data), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .done(done), .count(count),
        .halt_seen(halt_seen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] ovr [logic [31:0]];
    logic [31:0] imem_mem [logic [31:0]];
    logic [31:0] rd_log [$];

    // Model of the current/last transfer
    bit          active = 0;
    int          m_t = 0;
    int          m_n = 0;
    bit          m_h = 0;
    logic [31:0] m_db = '0;
    logic [31:0] m_ib = '0;
    bit          fin = 0;
    int          done_t = -1;
    int          wr_cnt = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] disk_word(logic [31:0] a);
        logic [31:0] w;
        if (ovr.exists(a)) return ovr[a];
        w = (a * 32'h9E3779B1) ^ 32'hC3A51F0E;
        if (w[31:26] == HALT) w[26] = ~w[26];
        return w;
    endfunction

    // Disk drives read data on the falling edge
    always @(negedge clk) disk_data = disk_word(disk_addr);

    // Model update and per-cycle compare
    initial begin
        int k;
        logic [31:0] w;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                active = 0; m_t = 0; m_n = 0; m_h = 0;
                m_db = '0; m_ib = '0;
            end else if (active) begin
                m_t++;
                if (m_t > 2 * m_n) active = 0;
            end else if (start) begin
                m_db = disk_base; m_ib = imem_base;
                m_n = 0; m_h = 0; m_t = 0; active = 1;
                for (int i = 0; i < int'(max_words); i++) begin
                    m_n = i + 1;
`ifdef DISK_LOADER_HALT_STOP_EN
                    w = disk_word(m_db + 32'(i));
                    if (w[31:26] == HALT) begin
                        m_h = 1;
                        break;
                    end
`endif
                end
            end
            #1;
            if (active) begin
                k = m_t / 2;
                check("busy", busy, 1);
                check("done", done, (m_t == 2 * m_n) ? 1 : 0);
                check("imem_we", imem_we,
                      (m_t < 2 * m_n && m_t % 2 == 1) ? 1 : 0);
                check("count", count, 32'(k));
                check("halt_seen", halt_seen,
                      (m_t == 2 * m_n) ? 32'(m_h) : 0);
                check("disk_addr", disk_addr, m_db + 32'(k));
                check("imem_addr", imem_addr, m_ib + 32'(k));
                if (imem_we)
                    check("imem_data", imem_data, disk_word(m_db + 32'(k)));
                if (m_t < 2 * m_n && m_t % 2 == 0) rd_log.push_back(disk_addr);
                if (done) done_t = m_t;
                if (m_t == 2 * m_n) fin = 1;
            end else begin
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_we", imem_we, 0);
                check("idle_count", count, 32'(m_n));
                check("idle_halt", halt_seen, 32'(m_h));
                check("idle_disk_addr", disk_addr, m_db + 32'(m_n));
                check("idle_imem_addr", imem_addr, m_ib + 32'(m_n));
            end
            if (imem_we) begin
                imem_mem[imem_addr] = imem_data;
                wr_cnt++;
            end
        end
    end

    task automatic launch(logic [31:0] db, logic [31:0] ib,
                          int mw, int hold);
        @(negedge clk);
        fin = 0; done_t = -1; wr_cnt = 0; rd_log.delete();
        disk_base = db; imem_base = ib;
        max_words = CNT_W'(mw); start = 1;
        repeat (hold) @(negedge clk);
        start = 0;
        disk_base = $urandom; imem_base = $urandom;
        max_words = CNT_W'($urandom);
    endtask

    task automatic finish_wait(int mw);
        for (int i = 0; i < 2 * mw + 20 && !fin; i++) @(negedge clk);
        check("xfer_timeout", fin, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run(logic [31:0] db, logic [31:0] ib,
                       int mw, int hold);
        launch(db, ib, mw, hold);
        finish_wait(mw);
    endtask

    initial begin
        logic [31:0] db;
        int mw;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Basic copy
        ovr[64] = 32'h11110001; ovr[65] = 32'h22220002;
        ovr[66] = 32'h33330003; ovr[67] = 32'h44440004;
        run(32'd64, 32'd0, 4, 1);
        check("basic_count", count, 4);
        check("basic_done_t", 32'(done_t), 8);
        check("basic_w0", imem_mem[0], 32'h11110001);
        check("basic_w1", imem_mem[1], 32'h22220002);
        check("basic_w2", imem_mem[2], 32'h33330003);
        check("basic_w3", imem_mem[3], 32'h44440004);
        ovr.delete();

        // Halt word at offset 3
        for (int i = 0; i < 6; i++) ovr[120 + i] = 32'h04000000 + 32'(i);
        ovr[123] = {HALT, 26'h0ABCDE};
        run(32'd120, 32'd500, 100, 1);
`ifdef DISK_LOADER_HALT_STOP_EN
        check("halt_count", count, 4);
        check("halt_flag", halt_seen, 1);
        check("halt_writes", 32'(wr_cnt), 4);
        check("halt_last", imem_mem[503], {HALT, 26'h0ABCDE});
`else
        check("nohalt_count", count, 100);
        check("nohalt_flag", halt_seen, 0);
        check("nohalt_word", imem_mem[503], {HALT, 26'h0ABCDE});
`endif
        ovr.delete();

        // Zero length
        run(32'd900, 32'd40, 0, 1);
        check("zero_count", count, 0);
        check("zero_writes", 32'(wr_cnt), 0);
        check("zero_done_t", 32'(done_t), 0);

        // Start while busy
        launch(32'd200, 32'd300, 3, 1);
        repeat (2) @(negedge clk);
        disk_base = 32'd7000; imem_base = 32'd8000;
        max_words = 9; start = 1;
        @(negedge clk);
        start = 0;
        finish_wait(3);
        check("busy_start_count", count, 3);
        check("busy_start_writes", 32'(wr_cnt), 3);
        check("busy_start_w2", imem_mem[302], disk_word(32'd202));

        // Reset during WRITE of word 2
        launch(32'd1000, 32'd2000, 5, 1);
        for (int i = 0; i < 20 && !(active && m_t == 5); i++)
            @(negedge clk);
        check("rst_pre_we", imem_we, 1);
        #1 rst_n = 0;
        #1;
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_disk_addr", disk_addr, 0);
        @(negedge clk);
        rst_n = 1;
        run(32'd4000, 32'd4100, 3, 2);
        check("post_rst_count", count, 3);
        check("post_rst_w0", imem_mem[4100], disk_word(32'd4000));

        // Address wrap
        run(32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1);
        check("wrap_rd0", rd_log.size() > 0 ? rd_log[0] : 32'hDEAD, 32'hFFFFFFFF);
        check("wrap_rd1", rd_log.size() > 1 ? rd_log[1] : 32'hDEAD, 32'h0);

        // Random transfers
        for (int n = 0; n < 30; n++) begin
            db = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : $urandom;
            mw = $urandom_range(0, 12);
            ovr.delete();
            if ($urandom_range(0, 1) == 1)
                ovr[db + 32'($urandom_range(0, 12))] = {HALT, 26'($urandom)};
            run(db, $urandom, mw, $urandom_range(1, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
